ccc_dyncfg_apb_master: RTL and testbench
========================================

// Module: ccc_dyncfg_apb_master
// PURPOSE
//  APB3 initiator driving the fabric CCC dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA, BUSY, LOCK).
//  Accepts single read/write commands over a valid/ready handshake and runs one APB transfer per command.
//  Optionally waits for PLL re-lock after a write.
//  Sits between the fabric config controller and the CCC macro wrapper; the CCC runs as the APB completer.
// PARAMETERS
//  ADDR_W        6       CCC config address width
//  DATA_W        8       CCC config data width
//  TIMEOUT_CYC   50000   max PCLK cycles spent waiting on BUSY low or LOCK high (>=2)
//  LOCK_BLANK    16      cycles after a write before LOCK is sampled (covers LOCK drop latency)
// PORTS
//  PCLK           in   1       single clock for the whole block
//  PRESET_N       in   1       async assert, active-low reset
//  cmd_valid      in   1       command present
//  cmd_ready      out  1       block idle, command accepted when valid&ready
//  cmd_write      in   1       1=write, 0=read
//  cmd_addr       in   ADDR_W  CCC register address
//  cmd_wdata      in   DATA_W  write data
//  cmd_wait_lock  in   1       writes only: wait for LOCK before responding
//  rsp_valid      out  1       1-cycle completion pulse, no backpressure
//  rsp_rdata      out  DATA_W  PRDATA captured (reads), 0 for writes
//  rsp_err        out  2       00 ok, 01 BUSY timeout, 10 LOCK timeout
//  PSEL/PENABLE/PWRITE  out 1  APB control to CCC
//  PADDR          out  ADDR_W  APB address
//  PWDATA         out  DATA_W  APB write data
//  PRDATA         in   DATA_W  APB read data
//  CCC_BUSY       in   1       CCC config busy (PCLK domain)
//  CCC_LOCK       in   1       PLL lock (asynchronous, synchronised here)
//  ccc_locked     out  1       2-FF synchronised CCC_LOCK
// BEHAVIOUR
//  Reset: state IDLE; PSEL/PENABLE/PWRITE=0; PADDR/PWDATA=0; rsp_valid=0; rsp_rdata=0; rsp_err=00; ccc_locked=0; counters=0.
//  cmd_ready = (state==IDLE), combinational; it is 1 during reset.
//  A command is captured into internal registers on the acceptance edge; later input changes are ignored.
//  FSM:
//   IDLE      -> WAIT_BUSY on accept.
//   WAIT_BUSY -> SETUP when CCC_BUSY=0.
//               -> RESP with err=01 when the counter reaches TIMEOUT_CYC-1; no APB transfer is issued.
//   SETUP     PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven -> ACCESS.
//   ACCESS    PSEL=1, PENABLE=1; PRDATA captured on exit for reads.
//               -> LOCK_WAIT if write&wait_lock, else RESP. No PREADY: ACCESS always lasts exactly 1 cycle.
//   LOCK_WAIT PSEL=PENABLE=0. Ignores ccc_locked for the first LOCK_BLANK cycles.
//               -> RESP ok on ccc_locked=1 afterwards.
//               -> RESP err=10 when the total wait reaches TIMEOUT_CYC.
//   RESP      rsp_valid=1 for exactly one cycle -> IDLE.
//  Latency (BUSY low, no lock wait): accept edge E; rsp_valid high in the cycle after edge E+3.
//  PSEL/PENABLE are 0 in every state except SETUP/ACCESS.
//  PADDR/PWDATA hold their last value while idle.
//  A single counter serves WAIT_BUSY and LOCK_WAIT. It clears on every state entry and saturates; it never wraps.
//  cmd_wait_lock is ignored for reads.
//  A new command is not accepted in the RESP cycle (cmd_ready=0). Back-to-back commands therefore take >=5 cycles each.
//  PRESET_N asserted mid-transfer: the APB transfer is aborted immediately (PSEL=0). The command is dropped with no rsp_valid.
//  LOCK dropping while not in LOCK_WAIT: only ccc_locked follows it; no FSM effect.
// STRUCTURE
//  Package ccc_cfg_pkg: state enum (IDLE, WAIT_BUSY, SETUP, ACCESS, LOCK_WAIT, RESP) and err codes ERR_OK/ERR_BUSY/ERR_LOCK.
//  Sub-module ccc_lock_sync: 2-FF synchroniser for CCC_LOCK, async active-low reset to 0.
//  Counter width: $clog2(TIMEOUT_CYC+1).
// TESTING
//  1 Read addr 0x05, BUSY=0, PRDATA=0xA5 -> SETUP/ACCESS one cycle each, PWRITE=0; rsp_valid 4 cycles after accept; rdata=A5; err=00.
//  2 Write 0x3F<=0x5C, wait_lock=1; LOCK drops, returns 100 cycles later -> PWDATA=5C; rsp err=00 only after ccc_locked=1, never inside the blank window.
//  3 BUSY held high for TIMEOUT_CYC+10 -> no PSEL pulse; rsp_err=01 after TIMEOUT_CYC cycles; cmd_ready returns.
//  4 Write wait_lock=1, LOCK held low -> rsp_err=10 exactly at TIMEOUT_CYC cycles; rdata=0.
//  5 PRESET_N low during ACCESS -> PSEL/PENABLE=0 asynchronously; no rsp_valid; next command completes normally.
//  6 cmd_valid held high with 3 queued commands -> each is accepted only in IDLE; 5-cycle spacing; APB protocol checker passes.

Source files
------------

// File: rtl/ccc_cfg_pkg.sv
// Shared types for the CCC dynamic-configuration APB initiator.
package ccc_cfg_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BUSY = 3'd1,
    SETUP     = 3'd2,
    ACCESS    = 3'd3,
    LOCK_WAIT = 3'd4,
    RESP      = 3'd5
  } state_t;

  // Completion status reported with each response
  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_BUSY = 2'b01,
    ERR_LOCK = 2'b10
  } err_t;

endpackage : ccc_cfg_pkg

// File: rtl/ccc_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the PCLK domain.
module ccc_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input; resets to "not locked"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : ccc_lock_sync

// File: rtl/ccc_dyncfg_apb_master.sv
// APB3 initiator for the CCC dynamic-configuration port: one APB transfer per
// accepted command, optional wait for PLL re-lock after writes.
module ccc_dyncfg_apb_master
  import ccc_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_BLANK  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_wait_lock,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              CCC_BUSY,
  input  logic              CCC_LOCK,
  output logic              ccc_locked
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(LOCK_BLANK);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic                r_wait_lock;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  err_t                r_rsp_err;
  logic                w_locked;
  logic [CNT_W-1:0]    w_cnt_next;

  // PLL lock into the PCLK domain
  ccc_lock_sync u_lock_sync (
    .clk     (PCLK),
    .rst_n   (PRESET_N),
    .i_async (CCC_LOCK),
    .o_sync  (w_locked)
  );

  // Shared wait counter increment; saturates instead of wrapping
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Controller FSM with registered APB and response outputs
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_wait_lock <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            // Snapshot the command; lock waiting only applies to writes
            r_write     <= cmd_write;
            r_wait_lock <= cmd_write & cmd_wait_lock;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_cnt       <= '0;
            r_state     <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (!CCC_BUSY) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= r_write;
            r_paddr   <= r_addr;
            r_pwdata  <= r_wdata;
            r_cnt     <= '0;
            r_state   <= SETUP;
          end else if (r_cnt == CNT_LAST) begin
            // Give up without touching the bus
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_BUSY;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end

        ACCESS: begin
          // Completer has no wait states, so ACCESS is always one cycle
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_rdata <= r_write ? '0 : PRDATA;
          r_cnt       <= '0;
          if (r_wait_lock) begin
            r_state <= LOCK_WAIT;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_OK;
            r_state     <= RESP;
          end
        end

        LOCK_WAIT: begin
          // Lock is ignored during the blanking window so a late drop is not missed
          if ((r_cnt >= CNT_BLANK) && w_locked) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_OK;
            r_cnt       <= '0;
            r_state     <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_LOCK;
            r_cnt       <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;
  assign ccc_locked = w_locked;

endmodule : ccc_dyncfg_apb_master

// File: tb/tb_ccc_dyncfg_apb_master.sv
// Directed self-checking bench for the CCC dynamic-configuration APB initiator.
module tb_ccc_dyncfg_apb_master;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned T      = 200;
  localparam int unsigned BLANK  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_wait_lock;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic [DATA_W-1:0] prdata_drv;
  logic              use_model;
  logic              busy;
  logic              lock;
  logic              ccc_locked;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor counters (written only by the monitor)
  int n_proto = 0;
  int n_setup = 0;
  int n_rsp   = 0;

  always #5 clk = ~clk;

  // Completer read data: directed value or a function of the address
  assign prdata = use_model ? ({2'b00, paddr} ^ 8'h5A) : prdata_drv;

  ccc_dyncfg_apb_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (T),
    .LOCK_BLANK  (BLANK)
  ) dut (
    .PCLK          (clk),
    .PRESET_N      (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wait_lock (cmd_wait_lock),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .PSEL          (psel),
    .PENABLE       (penable),
    .PWRITE        (pwrite),
    .PADDR         (paddr),
    .PWDATA        (pwdata),
    .PRDATA        (prdata),
    .CCC_BUSY      (busy),
    .CCC_LOCK      (lock),
    .ccc_locked    (ccc_locked)
  );

  // APB protocol monitor sampled mid-cycle
  bit              prev_psel, prev_pen, prev_pwrite;
  bit [ADDR_W-1:0] prev_paddr;
  bit [DATA_W-1:0] prev_pwdata;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_psel = 1'b0;
      prev_pen  = 1'b0;
    end else begin
      if (penable && !psel) n_proto++;
      if (penable && !(prev_psel && !prev_pen)) n_proto++;
      if (prev_psel && !prev_pen && !(psel && penable)) n_proto++;
      if (penable && (paddr != prev_paddr || pwrite != prev_pwrite || pwdata != prev_pwdata)) n_proto++;
      if (psel && !penable) n_setup++;
      if (rsp_valid) n_rsp++;
      prev_psel   = psel;
      prev_pen    = penable;
      prev_paddr  = paddr;
      prev_pwrite = pwrite;
      prev_pwdata = pwdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic wl);
    cmd_valid     = 1'b1;
    cmd_write     = w;
    cmd_addr      = a;
    cmd_wdata     = d;
    cmd_wait_lock = wl;
  endtask

  bit              early;
  int              save;
  int              n_acc, n_r;
  bit              acc;
  int              acc_cyc[3];
  logic [DATA_W-1:0] rsp_rd[3];
  logic            q_w[3];
  logic [ADDR_W-1:0] q_a[3];
  logic [DATA_W-1:0] q_d[3];

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wait_lock = 1'b0; prdata_drv = '0; use_model = 1'b0; busy = 1'b0; lock = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ccc_locked", ccc_locked, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("sync_locked", ccc_locked, 1);

    // 1: read 0x05 -> A5
    prdata_drv = 8'hA5;
    issue(1'b0, 6'h05, 8'h00, 1'b0);
    tick();
    chk("t1_ready_low", cmd_ready, 0);
    cmd_valid = 1'b0; cmd_addr = 6'h11;
    chk("t1_wait_psel", psel, 0);
    tick();
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_pen", penable, 0);
    chk("t1_setup_pwrite", pwrite, 0);
    chk("t1_setup_paddr", paddr, 6'h05);
    tick();
    chk("t1_access_psel", psel, 1);
    chk("t1_access_pen", penable, 1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_rdata", rsp_rdata, 8'hA5);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_psel", psel, 0);
    chk("t1_rsp_ready", cmd_ready, 0);
    tick();
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_ready", cmd_ready, 1);
    chk("t1_paddr_hold", paddr, 6'h05);

    // 2: write 0x3F<=0x5C with lock wait; LOCK drops and returns 100 cycles later
    issue(1'b1, 6'h3F, 8'h5C, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t2_pwrite", pwrite, 1);
    chk("t2_pwdata", pwdata, 8'h5C);
    chk("t2_paddr", paddr, 6'h3F);
    lock = 1'b0;
    tick();
    chk("t2_access_pen", penable, 1);
    tick();
    chk("t2_locked_dropped", ccc_locked, 0);
    early = 1'b0;
    repeat (98) begin tick(); if (rsp_valid) early = 1'b1; end
    lock = 1'b1;
    repeat (2) begin tick(); if (rsp_valid) early = 1'b1; end
    chk("t2_no_early_rsp", early, 0);
    chk("t2_locked_back", ccc_locked, 1);
    tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_err", rsp_err, 0);
    chk("t2_rsp_rdata", rsp_rdata, 0);
    tick();

    // 2b: lock held high -> response exactly when the blank window ends
    issue(1'b1, 6'h10, 8'h77, 1'b1);
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    repeat (19) begin tick(); if (rsp_valid) early = 1'b1; end
    chk("t2b_blank_respected", early, 0);
    tick();
    chk("t2b_rsp_valid", rsp_valid, 1);
    chk("t2b_rsp_err", rsp_err, 0);
    tick();

    // Read with wait_lock set: flag ignored, normal latency
    prdata_drv = 8'h3C;
    issue(1'b0, 6'h2A, 8'h00, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("rdwl_rsp_valid", rsp_valid, 1);
    chk("rdwl_rsp_rdata", rsp_rdata, 8'h3C);
    tick();

    // 3: BUSY stuck high -> busy timeout, no APB transfer
    busy = 1'b1;
    save = n_setup;
    issue(1'b1, 6'h01, 8'h11, 1'b0);
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    repeat (T - 1) begin tick(); if (rsp_valid) early = 1'b1; end
    chk("t3_no_early_rsp", early, 0);
    tick();
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_rdata", rsp_rdata, 0);
    chk("t3_psel", psel, 0);
    tick();
    chk("t3_ready_back", cmd_ready, 1);
    repeat (9) tick();
    chk("t3_no_psel", n_setup - save, 0);
    busy = 1'b0;

    // 3b: BUSY releases in the final counted cycle -> transfer wins over timeout
    busy = 1'b1;
    prdata_drv = 8'h6E;
    issue(1'b0, 6'h0C, 8'h00, 1'b0);
    tick();
    cmd_valid = 1'b0;
    repeat (T - 1) tick();
    busy = 1'b0;
    tick();
    chk("t3b_setup_psel", psel, 1);
    chk("t3b_no_rsp", rsp_valid, 0);
    tick(); tick();
    chk("t3b_rsp_valid", rsp_valid, 1);
    chk("t3b_rsp_err", rsp_err, 0);
    chk("t3b_rsp_rdata", rsp_rdata, 8'h6E);
    tick();

    // 4: LOCK held low -> lock timeout after T cycles of waiting
    lock = 1'b0;
    tick(); tick(); tick();
    issue(1'b1, 6'h20, 8'h99, 1'b1);
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    repeat (T + 2) begin tick(); if (rsp_valid) early = 1'b1; end
    chk("t4_no_early_rsp", early, 0);
    tick();
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_err", rsp_err, 2);
    chk("t4_rsp_rdata", rsp_rdata, 0);
    tick();
    lock = 1'b1;
    tick(); tick(); tick();

    // 5: reset during ACCESS aborts the transfer with no response
    prdata_drv = 8'h42;
    issue(1'b0, 6'h15, 8'h00, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("t5_access_pen", penable, 1);
    save = n_rsp;
    rst_n = 1'b0;
    #1;
    chk("t5_async_psel", psel, 0);
    chk("t5_async_pen", penable, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t5_no_rsp", n_rsp - save, 0);
    chk("t5_ready", cmd_ready, 1);
    prdata_drv = 8'h99;
    issue(1'b0, 6'h07, 8'h00, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5_next_rsp_valid", rsp_valid, 1);
    chk("t5_next_rdata", rsp_rdata, 8'h99);
    tick();

    // 6: three queued commands with cmd_valid held high
    use_model = 1'b1;
    q_w[0] = 1'b0; q_a[0] = 6'h01; q_d[0] = 8'h00;
    q_w[1] = 1'b1; q_a[1] = 6'h22; q_d[1] = 8'h44;
    q_w[2] = 1'b0; q_a[2] = 6'h33; q_d[2] = 8'h00;
    n_acc = 0; n_r = 0;
    issue(q_w[0], q_a[0], q_d[0], 1'b0);
    for (int c = 1; c <= 60 && n_r < 3; c++) begin
      acc = cmd_ready && cmd_valid;
      tick();
      if (acc) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc < 3) issue(q_w[n_acc], q_a[n_acc], q_d[n_acc], 1'b0);
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        rsp_rd[n_r] = rsp_rdata;
        n_r++;
      end
    end
    chk("t6_accepts", n_acc, 3);
    chk("t6_responses", n_r, 3);
    if (n_acc == 3) begin
      chk("t6_spacing_01", acc_cyc[1] - acc_cyc[0], 5);
      chk("t6_spacing_12", acc_cyc[2] - acc_cyc[1], 5);
    end
    if (n_r == 3) begin
      chk("t6_rdata0", rsp_rd[0], 8'h5B);
      chk("t6_rdata1", rsp_rd[1], 8'h00);
      chk("t6_rdata2", rsp_rd[2], 8'h69);
    end
    tick(); tick();
    chk("apb_protocol", n_proto, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ccc_dyncfg_apb_master
